// File: rtl/psram_arb_pkg.sv
// Shared encodings for the PSRAM access arbiter.
// FSM states, RAM command codes and owner ids.
package psram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    localparam logic [1:0] CMD_BURST_WR = 2'b01;
    localparam logic [1:0] CMD_BURST_RD = 2'b11;

    localparam logic OWNER_WR = 1'b0;
    localparam logic OWNER_RD = 1'b1;

    localparam int CHUNK_W = 9;

endpackage

// File: rtl/psram_access_arbiter_if.sv
// Requester and RAM-operator signals of the PSRAM arbiter.
// slave = arbiter side, master = environment side.
interface psram_access_arbiter_if #(
    parameter int ADDR_W = 23,
    parameter int LEN_W  = 16
);
    logic              iWrReq;
    logic [ADDR_W-1:0] iWrAddr;
    logic [LEN_W-1:0]  iWrLen;
    logic              oWrGnt;
    logic              oWrDone;
    logic              iRdReq;
    logic [ADDR_W-1:0] iRdAddr;
    logic [LEN_W-1:0]  iRdLen;
    logic              oRdGnt;
    logic              oRdDone;
    logic              oRamEn;
    logic [1:0]        oRamCmd;
    logic [ADDR_W-1:0] oRamAddr;
    logic [8:0]        oRamLen;
    logic              oRamOwner;
    logic              iRamDone;

    modport slave (
        input  iWrReq, iWrAddr, iWrLen,
        input  iRdReq, iRdAddr, iRdLen,
        input  iRamDone,
        output oWrGnt, oWrDone, oRdGnt, oRdDone,
        output oRamEn, oRamCmd, oRamAddr, oRamLen, oRamOwner
    );

    modport master (
        output iWrReq, iWrAddr, iWrLen,
        output iRdReq, iRdAddr, iRdLen,
        output iRamDone,
        input  oWrGnt, oWrDone, oRdGnt, oRdDone,
        input  oRamEn, oRamCmd, oRamAddr, oRamLen, oRamOwner
    );
endinterface

// File: rtl/psram_req_context.sv
// One requester context: address, remaining words, chunk sizing.
// PAGE_WORDS must be a power of two >= 2.
module psram_req_context
    import psram_arb_pkg::*;
#(
    parameter int ADDR_W     = 23,
    parameter int LEN_W      = 16,
    parameter int MAX_BURST  = 128,
    parameter int PAGE_WORDS = 1024
) (
    input  logic               iClk,
    input  logic               iRst_N,
    input  logic               en_i,
    input  logic               req_i,
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               chunk_done_i,
    output logic               pending_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic [CHUNK_W-1:0] chunk_o,
    output logic               gnt_o,
    output logic               done_o
);
    localparam int PW = $clog2(PAGE_WORDS);
    localparam int CW = (LEN_W > PW + 1) ? LEN_W + 1 : PW + 2;

    logic              active_q, active_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              gnt_q, gnt_d;
    logic              done_q, done_d;
    logic [CW-1:0]     room, lim;

    always_comb begin
        room = CW'(PAGE_WORDS) - CW'(addr_q[PW-1:0]);
        lim  = CW'(MAX_BURST);
        if (CW'(rem_q) < lim) lim = CW'(rem_q);
        if (room < lim) lim = room;
    end

    // done_q blocks re-acceptance until the cycle after the done pulse
    always_comb begin
        active_d = active_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        gnt_d    = 1'b0;
        done_d   = 1'b0;
        if (!en_i) begin
            active_d = 1'b0;
            addr_d   = '0;
            rem_d    = '0;
        end else if (active_q) begin
            if (rem_q == '0) begin
                done_d   = 1'b1;
                active_d = 1'b0;
            end else if (chunk_done_i) begin
                addr_d = addr_q + ADDR_W'(chunk_o);
                rem_d  = rem_q - LEN_W'(chunk_o);
            end
        end else if (req_i && !done_q) begin
            active_d = 1'b1;
            addr_d   = addr_i;
            rem_d    = len_i;
            gnt_d    = 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            active_q <= 1'b0;
            addr_q   <= '0;
            rem_q    <= '0;
            gnt_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
        end
    end

    assign chunk_o   = lim[CHUNK_W-1:0];
    assign pending_o = active_q && (rem_q != '0);
    assign addr_o    = addr_q;
    assign gnt_o     = gnt_q;
    assign done_o    = done_q;

endmodule

// File: rtl/psram_access_arbiter.sv
// Chunked PSRAM arbiter between capture writer and upload reader.
// Writer has priority, reader gets a chunk after STARVE_LIMIT writer chunks.
module psram_access_arbiter
    import psram_arb_pkg::*;
#(
    parameter int ADDR_W       = 23,
    parameter int LEN_W        = 16,
    parameter int MAX_BURST    = 128,
    parameter int PAGE_WORDS   = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input logic                  iClk,
    input logic                  iRst_N,
    input logic                  iEn,
    psram_access_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              wr_pend, rd_pend, pick_rd;
    logic              wr_cdone, rd_cdone;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [CHUNK_W-1:0] wr_chunk, rd_chunk;

    assign wr_cdone = iEn && (state_q == ST_WAIT) && bus.iRamDone
                      && (owner_q == OWNER_WR);
    assign rd_cdone = iEn && (state_q == ST_WAIT) && bus.iRamDone
                      && (owner_q == OWNER_RD);

    psram_req_context #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W),
        .MAX_BURST(MAX_BURST), .PAGE_WORDS(PAGE_WORDS)
    ) u_wr_ctx (
        .iClk(iClk), .iRst_N(iRst_N), .en_i(iEn),
        .req_i(bus.iWrReq), .addr_i(bus.iWrAddr), .len_i(bus.iWrLen),
        .chunk_done_i(wr_cdone), .pending_o(wr_pend),
        .addr_o(wr_addr), .chunk_o(wr_chunk),
        .gnt_o(bus.oWrGnt), .done_o(bus.oWrDone)
    );

    psram_req_context #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W),
        .MAX_BURST(MAX_BURST), .PAGE_WORDS(PAGE_WORDS)
    ) u_rd_ctx (
        .iClk(iClk), .iRst_N(iRst_N), .en_i(iEn),
        .req_i(bus.iRdReq), .addr_i(bus.iRdAddr), .len_i(bus.iRdLen),
        .chunk_done_i(rd_cdone), .pending_o(rd_pend),
        .addr_o(rd_addr), .chunk_o(rd_chunk),
        .gnt_o(bus.oRdGnt), .done_o(bus.oRdDone)
    );

    assign pick_rd = rd_pend && (!wr_pend || starve_q == STARVE_MAX);

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWNER_WR;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        if (!iEn) begin
            state_d  = ST_IDLE;
            starve_d = '0;
        end else begin
            if (!rd_pend) starve_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (wr_pend || rd_pend) begin
                        state_d = ST_ISSUE;
                        owner_d = pick_rd ? OWNER_RD : OWNER_WR;
                        if (pick_rd)
                            starve_d = '0;
                        else if (rd_pend && starve_q != STARVE_MAX)
                            starve_d = starve_q + SW'(1);
                    end
                end
                ST_ISSUE: state_d = ST_WAIT;
                ST_WAIT:  if (bus.iRamDone) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.oRamEn    = 1'b0;
        bus.oRamCmd   = 2'b00;
        bus.oRamAddr  = '0;
        bus.oRamLen   = '0;
        bus.oRamOwner = 1'b0;
        if (state_q != ST_IDLE) begin
            bus.oRamEn    = 1'b1;
            bus.oRamOwner = owner_q;
            if (owner_q == OWNER_RD) begin
                bus.oRamCmd  = CMD_BURST_RD;
                bus.oRamAddr = rd_addr;
                bus.oRamLen  = rd_chunk;
            end else begin
                bus.oRamCmd  = CMD_BURST_WR;
                bus.oRamAddr = wr_addr;
                bus.oRamLen  = wr_chunk;
            end
        end
    end

endmodule

// File: tb/tb_psram_access_arbiter.sv
// Directed bench for psram_access_arbiter with a small RAM responder.
// Chunks are logged at oRamEn rise and checked against hand values.
module tb_psram_access_arbiter;

    localparam int AW = 23;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    always #5 clk = ~clk;

    psram_access_arbiter_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();

    psram_access_arbiter #(
        .ADDR_W(AW), .LEN_W(LW), .MAX_BURST(128),
        .PAGE_WORDS(1024), .STARVE_LIMIT(4)
    ) dut (
        .iClk(clk), .iRst_N(rst_n), .iEn(en), .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] outs();
        outs = {bus.oWrGnt, bus.oWrDone, bus.oRdGnt, bus.oRdDone,
                bus.oRamEn, bus.oRamCmd, bus.oRamAddr, bus.oRamLen,
                bus.oRamOwner};
    endfunction

    typedef struct {
        logic owner;
        int   addr;
        int   len;
        int   gap;
    } ent_t;

    ent_t log_q[$];
    int cyc = 0;
    int done_cyc = -100;
    int rcnt = 0;
    int wr_done_cnt = 0;
    int rd_done_cnt = 0;
    bit ram_auto = 1'b1;
    bit prev_en = 1'b0;
    logic [34:0] held;

    always @(posedge clk) cyc++;

    // monitor first, then the RAM responder pulses iRamDone after 3 cycles
    always @(negedge clk) begin
        if (bus.oWrDone === 1'b1) wr_done_cnt++;
        if (bus.oRdDone === 1'b1) rd_done_cnt++;
        if (bus.oRamEn === 1'b1 && !prev_en) begin
            log_q.push_back('{bus.oRamOwner, int'(bus.oRamAddr),
                              int'(bus.oRamLen), cyc - done_cyc});
            check("cmd_vs_owner", 64'(bus.oRamCmd),
                  bus.oRamOwner ? 64'd3 : 64'd1);
            held = {bus.oRamCmd, bus.oRamAddr, bus.oRamLen, bus.oRamOwner};
        end else if (bus.oRamEn === 1'b1) begin
            check("ram_stable",
                  64'({bus.oRamCmd, bus.oRamAddr, bus.oRamLen, bus.oRamOwner}),
                  64'(held));
        end
        prev_en = (bus.oRamEn === 1'b1);
        bus.iRamDone = 1'b0;
        if (ram_auto && prev_en) begin
            rcnt++;
            if (rcnt == 3) begin
                bus.iRamDone = 1'b1;
                rcnt = 0;
                done_cyc = cyc;
            end
        end else begin
            rcnt = 0;
        end
    end

    task automatic req_wr(input int a, input int l);
        @(negedge clk);
        bus.iWrAddr = AW'(a);
        bus.iWrLen  = LW'(l);
        bus.iWrReq  = 1'b1;
        @(posedge clk);
        #1;
        check("wr_gnt", 64'(bus.oWrGnt), 64'd1);
        bus.iWrReq = 1'b0;
    endtask

    task automatic req_rd(input int a, input int l);
        @(negedge clk);
        bus.iRdAddr = AW'(a);
        bus.iRdLen  = LW'(l);
        bus.iRdReq  = 1'b1;
        @(posedge clk);
        #1;
        check("rd_gnt", 64'(bus.oRdGnt), 64'd1);
        bus.iRdReq = 1'b0;
    endtask

    task automatic wait_wr(input int target, input int budget);
        int n = 0;
        while (wr_done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("wr_done_count", 64'(wr_done_cnt), 64'(target));
    endtask

    task automatic wait_rd(input int target, input int budget);
        int n = 0;
        while (rd_done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("rd_done_count", 64'(rd_done_cnt), 64'(target));
    endtask

    task automatic chk_ent(input int i, input logic own, input int a,
                           input int l);
        if (i < log_q.size())
            check($sformatf("chunk%0d", i),
                  64'({log_q[i].owner, 23'(log_q[i].addr), 9'(log_q[i].len)}),
                  64'({own, 23'(a), 9'(l)}));
        else
            check($sformatf("chunk%0d_missing", i),
                  64'(log_q.size()), 64'(i + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb;
        int rb;
        int exp_a[9] = '{0, 128, 256, 384, 4096, 512, 640, 768, 896};
        logic exp_o[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

        bus.iWrReq = 1'b0; bus.iWrAddr = '0; bus.iWrLen = '0;
        bus.iRdReq = 1'b0; bus.iRdAddr = '0; bus.iRdLen = '0;

        repeat (3) @(negedge clk);
        check("reset_outs", 64'(outs()), 64'd0);
        rst_n = 1'b1;
        en = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_outs", 64'(outs()), 64'd0);

        // 300 words from 0: 128, 128, 44
        log_q.delete();
        wb = wr_done_cnt;
        req_wr(0, 300);
        wait_wr(wb + 1, 200);
        check("burst3_count", 64'(log_q.size()), 64'd3);
        chk_ent(0, 1'b0, 0, 128);
        chk_ent(1, 1'b0, 128, 128);
        chk_ent(2, 1'b0, 256, 44);
        if (log_q.size() >= 3) begin
            check("gap1", 64'(log_q[1].gap), 64'd2);
            check("gap2", 64'(log_q[2].gap), 64'd2);
        end

        // page split
        log_q.delete();
        wb = wr_done_cnt;
        req_wr(1000, 100);
        wait_wr(wb + 1, 200);
        check("split_count", 64'(log_q.size()), 64'd2);
        chk_ent(0, 1'b0, 1000, 24);
        chk_ent(1, 1'b0, 1024, 76);

        // zero-length reader
        log_q.delete();
        rb = rd_done_cnt;
        req_rd(77, 0);
        @(posedge clk);
        #1;
        check("rd0_done", 64'({bus.oRdGnt, bus.oRdDone}), 64'b01);
        repeat (3) @(negedge clk);
        check("rd0_no_ram", 64'(log_q.size()), 64'd0);
        check("rd0_done_count", 64'(rd_done_cnt), 64'(rb + 1));

        // address wrap
        log_q.delete();
        wb = wr_done_cnt;
        req_wr((1 << 23) - 10, 20);
        wait_wr(wb + 1, 200);
        check("wrap_count", 64'(log_q.size()), 64'd2);
        chk_ent(0, 1'b0, (1 << 23) - 10, 10);
        chk_ent(1, 1'b0, 0, 10);

        // both 1024 words: W,W,W,W,R,W,W,W,W then reader rest
        log_q.delete();
        wb = wr_done_cnt;
        rb = rd_done_cnt;
        @(negedge clk);
        bus.iWrAddr = 0;    bus.iWrLen = 1024; bus.iWrReq = 1'b1;
        bus.iRdAddr = 4096; bus.iRdLen = 1024; bus.iRdReq = 1'b1;
        @(posedge clk);
        #1;
        check("both_gnt", 64'({bus.oWrGnt, bus.oRdGnt}), 64'b11);
        bus.iWrReq = 1'b0;
        bus.iRdReq = 1'b0;
        wait_wr(wb + 1, 400);
        for (int i = 0; i < 9; i++)
            chk_ent(i, exp_o[i], exp_a[i], 128);
        wait_rd(rb + 1, 400);
        check("both_count", 64'(log_q.size()), 64'd16);
        chk_ent(9, 1'b1, 4224, 128);
        chk_ent(15, 1'b1, 4992, 128);

        // iEn abort in WAIT
        ram_auto = 1'b0;
        wb = wr_done_cnt;
        req_wr(100, 50);
        repeat (4) @(negedge clk);
        check("abort_en_busy", 64'({bus.oRamEn, bus.oRamLen}),
              64'({1'b1, 9'd50}));
        en = 1'b0;
        @(posedge clk);
        #1;
        check("en_abort_outs", 64'(outs()), 64'd0);
        @(negedge clk);
        en = 1'b1;
        repeat (6) @(negedge clk);
        check("en_abort_idle", 64'(outs()), 64'd0);
        check("en_abort_nodone", 64'(wr_done_cnt), 64'(wb));
        ram_auto = 1'b1;
        log_q.delete();
        req_wr(2000, 10);
        wait_wr(wb + 1, 200);
        check("en_fresh_count", 64'(log_q.size()), 64'd1);
        chk_ent(0, 1'b0, 2000, 10);

        // async reset in WAIT
        ram_auto = 1'b0;
        rb = rd_done_cnt;
        req_rd(300, 5);
        repeat (4) @(negedge clk);
        check("rst_busy", 64'({bus.oRamEn, bus.oRamAddr, bus.oRamLen}),
              64'({1'b1, 23'd300, 9'd5}));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_outs", 64'(outs()), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_idle", 64'(outs()), 64'd0);
        check("rst_nodone", 64'(rd_done_cnt), 64'(rb));
        ram_auto = 1'b1;
        log_q.delete();
        req_rd(500, 5);
        wait_rd(rb + 1, 200);
        check("rst_fresh_count", 64'(log_q.size()), 64'd1);
        chk_ent(0, 1'b1, 500, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/psram_access_arbiter.md
PSRAM_ACCESS_ARBITER -- requirements
Module: psram_access_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 23, PSRAM word-address width.
REQ-002 SHALL have parameter LEN_W, 16, request length width in words.
REQ-003 SHALL have parameter MAX_BURST, 128, max words per RAM chunk (1..256).
REQ-004 SHALL have parameter PAGE_WORDS, 1024, page size in words; power of two.
REQ-005 SHALL have parameter STARVE_LIMIT, 4, consecutive writer chunks before reader is forced a chunk.
REQ-006 SHALL have ports:
 iClk  in  1  clock.
 iRst_N  in  1  reset, asynchronous, active-low.
 iEn  in  1  block enable; low = synchronous abort/clear.
 iWrReq  in  1  capture-path request, level.
 iWrAddr  in  ADDR_W  writer start address.
 iWrLen  in  LEN_W  writer length, words.
 oWrGnt  out  1  one-cycle pulse: writer request accepted.
 oWrDone  out  1  one-cycle pulse: writer request fully transferred.
 iRdReq, iRdAddr, iRdLen, oRdGnt, oRdDone: same as writer, for the upload path.
 oRamEn  out  1  RAM-operator enable, held until done.
 oRamCmd  out  2  01 burst write (writer), 11 burst read (reader).
 oRamAddr  out  ADDR_W  chunk start address.
 oRamLen  out  9  chunk length, words.
 oRamOwner  out  1  0 writer, 1 reader; steers FIFO/UART data muxes.
 iRamDone  in  1  one-cycle pulse: current chunk complete.

Function
REQ-007 SHALL keep one context per requester: active flag, current address, remaining length.
REQ-008 SHALL accept a request when iEn=1, req=1 and its context is inactive: latch addr/len, pulse gnt the next cycle; both contexts may load in the same cycle.
REQ-009 SHALL require addr/len stable only in the cycle req is sampled; requester drops req after gnt; req held after done is accepted no earlier than the cycle after done.
REQ-010 SHALL accept len=0: gnt pulse, then done pulse the following cycle, no RAM access.
REQ-011 SHALL use FSM IDLE -> ISSUE -> WAIT -> IDLE; IDLE picks the owner when a context is active; ISSUE drives oRamEn=1 plus cmd/addr/len/owner; WAIT holds all RAM outputs stable until iRamDone.
REQ-012 SHALL set chunk = min(remaining, MAX_BURST, PAGE_WORDS - (addr mod PAGE_WORDS)); no chunk crosses a page boundary.
REQ-013 SHALL, on iRamDone in WAIT, drop oRamEn that cycle, add chunk to the address (wrap modulo 2^ADDR_W) and subtract chunk from remaining.
REQ-014 SHALL pulse the owner's done and clear its context in the cycle after remaining reaches 0.
REQ-015 SHALL arbitrate per chunk: writer wins when both are active, except reader wins once the starvation counter reaches STARVE_LIMIT.
REQ-016 SHALL increment the starvation counter per writer chunk granted while the reader is active, saturating at STARVE_LIMIT; it clears on any reader chunk or when the reader is inactive.
REQ-017 SHALL ignore iRamDone outside WAIT.
REQ-018 SHALL ensure minimum gap from iRamDone to next oRamEn rise is 2 cycles (WAIT->IDLE->ISSUE).
REQ-019 SHALL, on iEn=0, return FSM to IDLE, clear contexts and counter, and drive all outputs 0 on the next edge; no done pulse for aborted requests.

Reset
REQ-020 SHALL on iRst_N=0 asynchronously clear FSM to IDLE, contexts, counter; oWrGnt, oWrDone, oRdGnt, oRdDone, oRamEn, oRamCmd, oRamAddr, oRamLen, oRamOwner all 0.
REQ-021 SHALL resume only via new requests after reset release; no context survives reset mid-chunk.

Structure
REQ-022 SHALL place FSM state encoding, CMD_BURST_WR=01 / CMD_BURST_RD=11 constants and OWNER_WR/OWNER_RD in shared package psram_arb_pkg.
REQ-023 SHALL implement each context, including the chunk-size calculation, in sub-module psram_req_context, instantiated twice.

Verification
REQ-024 SHALL cover: writer addr=0,len=300, MAX_BURST=128 -> chunks 128,128,44 at addr 0,128,256; oWrDone once.
REQ-025 SHALL cover: writer addr=1000,len=100 -> chunks 24 @1000, 76 @1024 (page split).
REQ-026 SHALL cover: both request len=1024 same cycle -> both gnt same cycle; order W,W,W,W,R,W,W,W,W,R,... until writer done.
REQ-027 SHALL cover: reader len=0 -> oRdGnt then oRdDone next cycle, oRamEn never rises.
REQ-028 SHALL cover: addr=2^23-10,len=20 -> chunks 10 @2^23-10 and 10 @0.
REQ-029 SHALL cover: iEn dropped, and separately iRst_N asserted, during WAIT -> all outputs 0 next edge (async for reset), no done; fresh request afterwards starts at its new address.
